// File: rtl/log_reader.sv
// log_reader: read-side controller for the sample logger.
// Arms a capture, waits for the logger to report full, then sweeps every
// logger address and streams the stored samples over valid/ready.
// Optional feature macro: LOG_READER_TIMEOUT_EN adds a capture watchdog that
// aborts to IDLE with an o_error pulse after 2^ADDR_WIDTH+8 cycles without
// i_mem_full. Without the macro, CAPTURE waits forever and o_error is 0.
module log_reader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_run_log,
    output logic                  o_read_log,
    output logic [ADDR_WIDTH-1:0] o_addr_log,
    input  logic                  i_mem_full,
    input  logic [31:0]           i_data_log,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_SETTLE,
        ST_FETCH,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic                    run_log_q;
    logic                    read_log_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   sample_d;
    logic                    valid_q;
    logic                    last_q;
    logic                    busy_q;
    logic                    done_q;
    logic [1:0]              fetch_cnt_q;
    logic                    addr_is_last;

`ifdef LOG_READER_TIMEOUT_EN
    localparam int WD_W = ADDR_WIDTH + 2;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((2 ** ADDR_WIDTH) + 7);
    logic [WD_W-1:0] wdog_q;
    logic            error_q;
`endif

    // Only the low DATA_WIDTH bits of the logger word carry the sample.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_slice
        assign sample_d[gi] = i_data_log[gi];
    end

    logic unused_hi;
    assign unused_hi = ^i_data_log[31:DATA_WIDTH];

    // Next sweep address and end-of-sweep detection.
    always_comb begin
        addr_d       = addr_q + ADDR_WIDTH'(1);
        addr_is_last = &addr_q;
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            run_log_q   <= 1'b0;
            read_log_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fetch_cnt_q <= '0;
`ifdef LOG_READER_TIMEOUT_EN
            wdog_q      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef LOG_READER_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q   <= ST_ARM;
                        run_log_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_ARM: begin
                    state_q   <= ST_CAPTURE;
                    run_log_q <= 1'b0;
`ifdef LOG_READER_TIMEOUT_EN
                    wdog_q    <= '0;
`endif
                end
                ST_CAPTURE: begin
                    if (i_mem_full) begin
                        state_q    <= ST_SETTLE;
                        read_log_q <= 1'b1;
                        addr_q     <= '0;
`ifdef LOG_READER_TIMEOUT_EN
                    end else if (wdog_q == WD_LAST) begin
                        // Logger never filled: give up and report it.
                        state_q    <= ST_IDLE;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        read_log_q <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
`endif
                    end
                end
                ST_SETTLE: begin
                    state_q     <= ST_FETCH;
                    fetch_cnt_q <= '0;
                end
                ST_FETCH: begin
                    // Address has been stable RD_LAT cycles: data is valid now.
                    if (fetch_cnt_q == 2'(RD_LAT)) begin
                        state_q <= ST_OUT;
                        data_q  <= sample_d;
                        last_q  <= addr_is_last;
                        valid_q <= 1'b1;
                    end else begin
                        fetch_cnt_q <= fetch_cnt_q + 2'd1;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (addr_is_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_FETCH;
                            addr_q      <= addr_d;
                            fetch_cnt_q <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    read_log_q <= 1'b0;
                    busy_q     <= 1'b0;
                    addr_q     <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_run_log  = run_log_q;
    assign o_read_log = read_log_q;
    assign o_addr_log = addr_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
`ifdef LOG_READER_TIMEOUT_EN
    assign o_error    = error_q;
`else
    assign o_error    = 1'b0;
`endif

endmodule

// File: tb/tb_log_reader.sv
// tb_log_reader: directed bench for log_reader with a behavioural logger
// that returns 0x0101*a at address a (upper word filled with junk).
module tb_log_reader;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          o_run_log;
    logic          o_read_log;
    logic [AW-1:0] o_addr_log;
    logic          i_mem_full;
    logic [31:0]   i_data_log = '0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    log_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_run_log  (o_run_log),
        .o_read_log (o_read_log),
        .o_addr_log (o_addr_log),
        .i_mem_full (i_mem_full),
        .i_data_log (i_data_log),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    always #5 clk = ~clk;

    // ---------------- logger model ----------------
    int full_mode = 0;   // 0: full 16 cycles after run_log, 1: forced high, 2: forced low
    int full_cnt  = 0;

    always @(posedge clk) begin
        i_data_log <= {16'hDEAD, 16'h0101 * 16'(o_addr_log)};
        if (o_run_log)
            full_cnt <= 1;
        else if (full_cnt != 0 && full_cnt < 16)
            full_cnt <= full_cnt + 1;
    end

    assign i_mem_full = (full_mode == 1) || (full_mode == 0 && full_cnt == 16);

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int run_cnt = 0, run_cyc = 0, done_cnt = 0, done_cyc = 0;
    int err_cnt = 0, err_cyc = 0, read_rise_cyc = 0, stall_viol = 0;
    bit prev_stall = 0, prev_read = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] hs_data[$];
    bit            hs_last[$];
    int            hs_cyc[$];

    always @(negedge clk) begin
        if (o_run_log) begin run_cnt++; run_cyc = cyc; end
        if (o_done)    begin done_cnt++; done_cyc = cyc; end
        if (o_error)   begin err_cnt++; err_cyc = cyc; end
        if (o_read_log && !prev_read) read_rise_cyc = cyc;
        prev_read = o_read_log;
        if (prev_stall && !i_rst && (!o_valid || o_data != prev_data)) stall_viol++;
        if (o_valid && i_ready) begin
            hs_data.push_back(o_data);
            hs_last.push_back(o_last);
            hs_cyc.push_back(cyc);
        end
        prev_stall = o_valid && !i_ready && !i_rst;
        prev_data  = o_data;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_mon();
        hs_data.delete();
        hs_last.delete();
        hs_cyc.delete();
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    logic [7:0] lfsr = 8'hA5;

    // Runs until o_done is seen (or reset injected at address 7), bounded.
    task automatic run_until_done(input bit bp, input bit inj, input bit rst7, output bit rst_hit);
        int  old_done = done_cnt;
        bit  inj2     = 1'b0;
        bit  finished = 1'b0;
        rst_hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (bp) begin
                lfsr    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                i_ready = lfsr[0];
            end else begin
                i_ready = 1'b1;
            end
            if (inj && i == 5) i_start = 1'b1;
            if (inj && !inj2 && o_valid && hs_data.size() >= 3) begin
                i_start = 1'b1;
                inj2    = 1'b1;
            end
            if (rst7 && o_valid && o_addr_log == 4'd7) begin
                i_rst    = 1'b1;
                rst_hit  = 1'b1;
                finished = 1'b1;
                break;
            end
            if (done_cnt != old_done) begin
                finished = 1'b1;
                break;
            end
        end
        i_start = 1'b0;
        check_eq("dump_finished_in_budget", finished, 1);
    endtask

    task automatic check_dump(input string tag);
        check_eq({tag, "_count"}, hs_data.size(), 16);
        for (int a = 0; a < 16 && a < hs_data.size(); a++) begin
            check_eq($sformatf("%s_data%0d", tag, a), hs_data[a], 32'(16'h0101 * 16'(a)));
            check_eq($sformatf("%s_last%0d", tag, a), hs_last[a], (a == 15) ? 1 : 0);
        end
    endtask

    // ---------------- stimulus ----------------
    int base_run, base_done, base_err;
    bit hit;
    bit got;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {o_run_log, o_read_log, o_addr_log, o_data,
                                   o_valid, o_last, o_busy, o_done, o_error}, 0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        // Nominal dump
        clear_mon(); base_run = run_cnt; base_done = done_cnt;
        start_pulse();
        run_until_done(1'b0, 1'b0, 1'b0, hit);
        check_eq("nom_busy_after_done", o_busy, 0);
        check_eq("nom_read_after_done", o_read_log, 0);
        check_dump("nom");
        check_eq("nom_read_rise", read_rise_cyc - run_cyc, 17);
        if (hs_cyc.size() == 16) begin
            check_eq("nom_first_valid", hs_cyc[0] - run_cyc, 20);
            for (int a = 1; a < 16; a++)
                check_eq($sformatf("nom_gap%0d", a), hs_cyc[a] - hs_cyc[a-1], 3);
            check_eq("nom_done_after_last", done_cyc - hs_cyc[15], 1);
        end
        repeat (3) @(posedge clk);
        check_eq("nom_run_pulses", run_cnt - base_run, 1);
        check_eq("nom_done_pulses", done_cnt - base_done, 1);

        // Backpressure
        clear_mon(); stall_viol = 0;
        start_pulse();
        run_until_done(1'b1, 1'b0, 1'b0, hit);
        i_ready = 1'b1;
        check_dump("bp");
        check_eq("bp_stall_stable", stall_viol, 0);

        // Start ignored while busy
        clear_mon(); base_run = run_cnt;
        start_pulse();
        run_until_done(1'b0, 1'b1, 1'b0, hit);
        repeat (5) @(posedge clk);
        check_eq("inj_run_pulses", run_cnt - base_run, 1);
        check_eq("inj_idle_busy", o_busy, 0);
        check_dump("inj");

        // Reset mid-sweep
        clear_mon();
        start_pulse();
        run_until_done(1'b0, 1'b0, 1'b1, hit);
        check_eq("rst_reached_addr7", hit, 1);
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_eq("rst_outputs", {o_run_log, o_read_log, o_addr_log, o_data,
                                 o_valid, o_last, o_done, o_error}, 0);
        check_eq("rst_busy", o_busy, 0);
        clear_mon();
        start_pulse();
        run_until_done(1'b0, 1'b0, 1'b0, hit);
        check_dump("redump");

        // Full already asserted
        full_mode = 1;
        clear_mon();
        start_pulse();
        run_until_done(1'b0, 1'b0, 1'b0, hit);
        check_eq("pre_read_rise", read_rise_cyc - run_cyc, 2);
        if (hs_cyc.size() > 0) check_eq("pre_first_valid", hs_cyc[0] - run_cyc, 5);
        check_dump("pre");
        full_mode = 0;

        // Capture timeout
        full_mode = 2;
        clear_mon(); base_err = err_cnt;
        start_pulse();
`ifdef LOG_READER_TIMEOUT_EN
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (err_cnt != base_err) begin got = 1'b1; break; end
        end
        check_eq("to_error_seen", got, 1);
        check_eq("to_error_cycle", err_cyc - run_cyc, 25);
        check_eq("to_busy", o_busy, 0);
        check_eq("to_read", o_read_log, 0);
        repeat (3) @(posedge clk);
        check_eq("to_error_pulses", err_cnt - base_err, 1);
`else
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check_eq("nto_busy", o_busy, 1);
        check_eq("nto_read", o_read_log, 0);
        check_eq("nto_run", o_run_log, 0);
        check_eq("nto_error_pulses", err_cnt - base_err, 0);
`endif
        full_mode = 0;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
